uart_rx_sampler: RTL and testbench

UART receive front end: converts the asynchronous serial line `rx_in` (8N1, LSB first, idle high) into parallel bytes plus a per-bit serial stream. It contains a fractional baud-tick generator running at 16× the baud rate and an oversampling receive FSM. It sits directly behind the board RX pin and feeds the downstream pattern-matching logic.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_baud_gen.sv | 32 +++
 rtl/uart_rx_sampler.sv | 130 +++++++++++++
 tb/tb_uart_rx_sampler.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, default rates
// and mid-bit sample points.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

  localparam int unsigned DEF_CLK_FREQ   = 25_000_000;
  localparam int unsigned DEF_BAUD_RATE  = 115_200;
  localparam int unsigned DEF_OVERSAMPLE = 16;

  // Tick counts at which the line is sampled (mid start bit / mid data bit)
  localparam logic [3:0] MID_START = 4'd7;
  localparam logic [3:0] MID_BIT   = 4'd15;
endpackage

// File: rtl/uart_baud_gen.sv
// Fractional baud-tick generator: 32-bit phase accumulator, one-cycle strobe
// at BAUD_RATE*OVERSAMPLE on average.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
  parameter int unsigned BAUD_RATE  = DEF_BAUD_RATE,
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic sys_clk,
  input  logic reset,
  output logic baud_tick
);
  localparam logic [31:0] INC = 32'(BAUD_RATE * OVERSAMPLE);
  localparam logic [31:0] LIM = 32'(CLK_FREQ);

  logic [31:0] acc, sum;
  assign sum = acc + INC;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      baud_tick <= 1'b0;
    end else if (sum >= LIM) begin
      acc       <= sum - LIM;
      baud_tick <= 1'b1;
    end else begin
      acc       <= sum;
      baud_tick <= 1'b0;
    end
  end
endmodule

// File: rtl/uart_rx_sampler.sv
// UART 8N1 receive front end: baud ticks, 2-FF input synchronizer and a
// 16x oversampling FSM producing bytes and a per-bit serial stream.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
  parameter int unsigned BAUD_RATE  = DEF_BAUD_RATE,
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic       baud_tick,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       serial_out,
  output logic       serial_valid
);
  uart_baud_gen #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .baud_tick (baud_tick)
  );

  logic rx_meta, rx_s;
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  rx_state_e  state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n, data_n;
  logic       armed, armed_n, sout_n, sv_n, dv_n;

  // After a framing error the line may still be low; armed blocks a false
  // start until it has been seen high again.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    armed_n = armed;
    data_n  = data_out;
    sout_n  = serial_out;
    sv_n    = 1'b0;
    dv_n    = 1'b0;
    if (baud_tick) begin
      case (state)
        IDLE: begin
          if (!armed) armed_n = rx_s;
          else if (!rx_s) begin
            state_n = START;
            cnt_n   = '0;
          end
        end
        START: begin
          if (cnt == MID_START) begin
            if (!rx_s) begin
              state_n = DATA;
              cnt_n   = '0;
              idx_n   = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            cnt_n = 4'(cnt + 4'd1);
          end
        end
        DATA: begin
          cnt_n = 4'(cnt + 4'd1);
          if (cnt == MID_BIT) begin
            sh_n   = {rx_s, sh[7:1]};
            sout_n = rx_s;
            sv_n   = 1'b1;
            if (idx == 3'd7) state_n = STOP;
            else             idx_n   = 3'(idx + 3'd1);
          end
        end
        STOP: begin
          cnt_n = 4'(cnt + 4'd1);
          if (cnt == MID_BIT) begin
            state_n = IDLE;
            if (rx_s) begin
              data_n = sh;
              dv_n   = 1'b1;
            end else begin
              armed_n = 1'b0;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      sh           <= '0;
      armed        <= 1'b1;
      data_out     <= '0;
      data_valid   <= 1'b0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      idx          <= idx_n;
      sh           <= sh_n;
      armed        <= armed_n;
      data_out     <= data_n;
      data_valid   <= dv_n;
      serial_out   <= sout_n;
      serial_valid <= sv_n;
    end
  end
endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: a line-level model queues the bits and bytes each
// sent frame must yield; a monitor checks every output pulse against it.
`timescale 1ns/1ps
module tb_uart_rx_sampler;
  localparam int BIT_NS = 8680;

  logic       sys_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       rx_in   = 1'b1;
  logic       baud_tick, data_valid, serial_out, serial_valid;
  logic [7:0] data_out;

  int checks = 0;
  int failures = 0;
  int sv_cnt = 0;
  int dv_cnt = 0;
  logic [7:0] sv_log = '0;

  logic bq[$];
  logic [7:0] byq[$];

  uart_rx_sampler dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .rx_in        (rx_in),
    .baud_tick    (baud_tick),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .serial_out   (serial_out),
    .serial_valid (serial_valid)
  );

  always #20 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a sent frame produces its 8 bits LSB first, and its byte only if
  // the stop bit is high.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    for (int i = 0; i < 8; i++) bq.push_back(b[i]);
    if (stop) byq.push_back(b);
    rx_in = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      #(BIT_NS);
    end
    rx_in = stop;
    #(BIT_NS);
    rx_in = 1'b1;
  endtask

  task automatic drain(input string name);
    #(2 * BIT_NS);
    chk({name, "_bits_left"}, bq.size(), 0);
    chk({name, "_bytes_left"}, byq.size(), 0);
  endtask

  always @(negedge sys_clk) begin
    if (!reset) begin
      if (serial_valid || data_valid) chk("pulse_overlap", {serial_valid, data_valid} == 2'b11, 0);
      if (serial_valid) begin
        sv_cnt++;
        sv_log = {serial_out, sv_log[7:1]};
        if (bq.size() == 0) chk("unexpected_serial_valid", 1, 0);
        else chk("serial_out", serial_out, bq.pop_front());
      end
      if (data_valid) begin
        dv_cnt++;
        if (byq.size() == 0) chk("unexpected_data_valid", 1, 0);
        else chk("data_out", data_out, byq.pop_front());
      end
    end
  end

  initial begin
    int sv0, dv0, nt;
    #50;
    chk("reset_outputs", {baud_tick, data_valid, serial_valid, serial_out, data_out}, 0);
    #50 reset = 1'b0;
    #5000;

    sv0 = sv_cnt; dv0 = dv_cnt;
    send_frame(8'hD6, 1'b1);
    drain("d6");
    chk("d6_sv_pulses", sv_cnt - sv0, 8);
    chk("d6_dv_pulses", dv_cnt - dv0, 1);
    chk("d6_bits", sv_log, 8'b1101_0110);
    chk("d6_data", data_out, 8'hD6);

    #20000;
    sv0 = sv_cnt; dv0 = dv_cnt;
    send_frame(8'h35, 1'b1);
    drain("x35");
    chk("x35_dv_pulses", dv_cnt - dv0, 1);
    chk("x35_bits", sv_log, 8'b0011_0101);
    chk("x35_data", data_out, 8'h35);

    sv0 = sv_cnt; dv0 = dv_cnt;
    rx_in = 1'b0; #2000; rx_in = 1'b1;
    #(3 * BIT_NS);
    chk("glitch_sv", sv_cnt - sv0, 0);
    chk("glitch_dv", dv_cnt - dv0, 0);

    sv0 = sv_cnt; dv0 = dv_cnt;
    send_frame(8'hA5, 1'b0);
    drain("ferr");
    chk("ferr_sv_pulses", sv_cnt - sv0, 8);
    chk("ferr_dv_pulses", dv_cnt - dv0, 0);
    chk("ferr_data_hold", data_out, 8'h35);

    // 0xC3 interrupted by reset mid bit 4: only bits 0..3 get sampled
    sv0 = sv_cnt;
    bq.push_back(1'b1); bq.push_back(1'b1); bq.push_back(1'b0); bq.push_back(1'b0);
    rx_in = 1'b0; #(BIT_NS);
    rx_in = 1'b1; #(BIT_NS);
    rx_in = 1'b1; #(BIT_NS);
    rx_in = 1'b0; #(BIT_NS);
    rx_in = 1'b0; #(BIT_NS);
    rx_in = 1'b0; #2000;
    reset = 1'b1;
    #200;
    @(negedge sys_clk);
    chk("midreset_outputs", {baud_tick, data_valid, serial_valid, serial_out, data_out}, 0);
    rx_in = 1'b1;
    #100 reset = 1'b0;
    chk("midreset_sv_before", sv_cnt - sv0, 4);
    #(3 * BIT_NS);
    chk("midreset_no_dv", data_valid | serial_valid, 0);

    dv0 = dv_cnt;
    send_frame(8'h5A, 1'b1);
    drain("x5a");
    chk("x5a_dv_pulses", dv_cnt - dv0, 1);
    chk("x5a_data", data_out, 8'h5A);

    dv0 = dv_cnt;
    send_frame(8'h81, 1'b1);
    send_frame(8'h7E, 1'b1);
    drain("b2b");
    chk("b2b_dv_pulses", dv_cnt - dv0, 2);
    chk("b2b_data", data_out, 8'h7E);

    nt = 0;
    repeat (25000) begin
      @(negedge sys_clk);
      if (baud_tick) nt++;
    end
    checks++;
    if (nt < 1842 || nt > 1844) begin
      failures++;
      $display("FAIL baud_1ms: got %0d ticks expected 1843 +/-1", nt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
